// File: rtl/k6502_sequencer_pkg.sv
// Shared definitions for the k6502 execution sequencer: control-word field
// layout, address-mode encoding and the sequencer's per-edge actions.
package k6502_sequencer_pkg;

    localparam int X_BITS      = 8;
    localparam int X_ADDR_MODE = 7;
    localparam int X_DLLATCH_H = 6;
    localparam int X_DLLATCH_L = 5;
    localparam int X_PCLATCH_H = 4;
    localparam int X_PCLATCH_L = 3;
    localparam int X_INC_DL    = 2;
    localparam int X_INC_PC    = 1;
    localparam int X_SYNC_NEXT = 0;

    localparam logic ADDR_MODE_PC = 1'b0;
    localparam logic ADDR_MODE_DL = ~ADDR_MODE_PC;

    localparam logic [5:0] CYCLE_RESET = 6'b000000;

    typedef struct packed {
        logic addr_mode;
        logic dllatch_h;
        logic dllatch_l;
        logic pclatch_h;
        logic pclatch_l;
        logic inc_dl;
        logic inc_pc;
        logic sync_next;
    } ctrl_t;

    typedef enum logic [2:0] {
        SEQ_HOLD,
        SEQ_FETCH,
        SEQ_START,
        SEQ_OVERFLOW,
        SEQ_SHIFT
    } seq_op_t;

    function automatic ctrl_t decode_ctrl(input logic [X_BITS-1:0] word);
        ctrl_t c;
        c.addr_mode = word[X_ADDR_MODE];
        c.dllatch_h = word[X_DLLATCH_H];
        c.dllatch_l = word[X_DLLATCH_L];
        c.pclatch_h = word[X_PCLATCH_H];
        c.pclatch_l = word[X_PCLATCH_L];
        c.inc_dl    = word[X_INC_DL];
        c.inc_pc    = word[X_INC_PC];
        c.sync_next = word[X_SYNC_NEXT];
        return c;
    endfunction

endpackage

// File: rtl/k6502_sequencer_addr_reg.sv
// 16-bit address register with optional increment and per-byte load from the
// data bus. Used for both the program counter and the data latch.
module k6502_sequencer_addr_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        inc,
    input  logic        latch_l,
    input  logic        latch_h,
    input  logic [7:0]  data_in,
    output logic [15:0] q
);

    logic [15:0] q_inc;
    logic [15:0] q_next;

    // Carry is resolved on the full word first, so a latched byte replaces
    // whatever the increment produced in that half.
    always_comb begin
        q_inc  = inc ? q + 16'd1 : q;
        q_next = q_inc;
        if (latch_l) q_next[7:0]  = data_in;
        if (latch_h) q_next[15:8] = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/k6502_sequencer.sv
// k6502 execution sequencer: executes the microcode control word, owns PC/DL,
// drives the bus address and produces {ir, cycle} for the microcode ROM.
module k6502_sequencer
    import k6502_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CYCLE_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready,
    input  logic [7:0]         data_in,
    input  logic [X_BITS-1:0]  x,
    output logic [7:0]         ir,
    output logic [CYCLE_W-1:0] cycle,
    output logic [15:0]        addr,
    output logic [15:0]        pc,
    output logic [15:0]        dl,
    output logic               sync,
    output logic               fault
);

    localparam logic [CYCLE_W-1:0] CYCLE_T1 = CYCLE_W'(1);

    ctrl_t   ctrl;
    seq_op_t seq_op;

    assign ctrl = decode_ctrl(x);

    always_comb begin
        addr = (ctrl.addr_mode == ADDR_MODE_DL) ? dl : pc;
        sync = ctrl.sync_next;
    end

    // An opcode fetch wins over everything else, including overflow.
    always_comb begin
        seq_op = SEQ_HOLD;
        if (ready) begin
            if (ctrl.sync_next)
                seq_op = SEQ_FETCH;
            else if (cycle == CYCLE_W'(CYCLE_RESET))
                seq_op = SEQ_START;
            else if (cycle[CYCLE_W-1])
                seq_op = SEQ_OVERFLOW;
            else
                seq_op = SEQ_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= 8'h00;
            cycle <= CYCLE_W'(CYCLE_RESET);
            fault <= 1'b0;
        end else begin
            fault <= 1'b0;
            case (seq_op)
                SEQ_FETCH: begin
                    ir    <= data_in;
                    cycle <= CYCLE_T1;
                end
                SEQ_START: begin
                    cycle <= CYCLE_T1;
                end
                SEQ_OVERFLOW: begin
                    ir    <= 8'h00;
                    cycle <= CYCLE_W'(CYCLE_RESET);
                    fault <= 1'b1;
                end
                SEQ_SHIFT: begin
                    cycle <= cycle << 1;
                end
                default: begin
                    cycle <= cycle;
                end
            endcase
        end
    end

    k6502_sequencer_addr_reg #(
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ready),
        .inc    (ctrl.inc_pc),
        .latch_l(ctrl.pclatch_l),
        .latch_h(ctrl.pclatch_h),
        .data_in(data_in),
        .q      (pc)
    );

    k6502_sequencer_addr_reg #(
        .RESET_VAL(16'h0000)
    ) u_dl_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ready),
        .inc    (ctrl.inc_dl),
        .latch_l(ctrl.dllatch_l),
        .latch_h(ctrl.dllatch_h),
        .data_in(data_in),
        .q      (dl)
    );

endmodule

// File: tb/tb_k6502_sequencer.sv
// Self-checking bench for k6502_sequencer: a small bench-side microcode ROM and
// memory close the fetch loop; expected register snapshots go through a queue.
module tb_k6502_sequencer;

    localparam logic [7:0] XB_AM_DL  = 8'h80;
    localparam logic [7:0] XB_DLH    = 8'h40;
    localparam logic [7:0] XB_DLL    = 8'h20;
    localparam logic [7:0] XB_PCH    = 8'h10;
    localparam logic [7:0] XB_PCL    = 8'h08;
    localparam logic [7:0] XB_INC_DL = 8'h04;
    localparam logic [7:0] XB_INC_PC = 8'h02;
    localparam logic [7:0] XB_SYNC   = 8'h01;

    typedef struct packed {
        logic [7:0]  ir;
        logic [5:0]  cycle;
        logic [15:0] pc;
        logic [15:0] dl;
        logic        fault;
    } snap_t;

    typedef struct {
        string tag;
        snap_t st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  data_in;
    logic [7:0]  x;
    logic [7:0]  ir;
    logic [5:0]  cycle;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] dl;
    logic        sync;
    logic        fault;

    logic        use_rom = 1'b1;
    logic        use_mem = 1'b1;
    logic [7:0]  x_drv = 8'h00;
    logic [7:0]  din_drv = 8'h00;
    logic [7:0]  mem [0:65535];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    k6502_sequencer #(
        .RESET_PC(16'h8000),
        .CYCLE_W (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ready  (ready),
        .data_in(data_in),
        .x      (x),
        .ir     (ir),
        .cycle  (cycle),
        .addr   (addr),
        .pc     (pc),
        .dl     (dl),
        .sync   (sync),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    // Bench microcode: reset row fetches, EA is a one-cycle NOP, 6C is JMP
    // (indirect) through DL, anything else issues the all-zero default word.
    function automatic logic [7:0] rom_word(input logic [7:0] op, input logic [5:0] cyc);
        if (cyc == 6'd0) return XB_SYNC | XB_INC_PC;
        case (op)
            8'hEA: return XB_SYNC | XB_INC_PC;
            8'h6C: begin
                case (cyc)
                    6'b000001: return XB_DLL | XB_INC_PC;
                    6'b000010: return XB_DLH | XB_INC_PC;
                    6'b000100: return XB_AM_DL | XB_PCL | XB_INC_DL;
                    6'b001000: return XB_AM_DL | XB_PCH;
                    6'b010000: return XB_SYNC | XB_INC_PC;
                    default:   return 8'h00;
                endcase
            end
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        x       = use_rom ? rom_word(ir, cycle) : x_drv;
        data_in = use_mem ? mem[addr] : din_drv;
    end

    function automatic snap_t observe();
        snap_t s;
        s = {ir, cycle, pc, dl, fault};
        return s;
    endfunction

    function automatic void push_exp(input string tag, input logic [7:0] e_ir,
                                     input logic [5:0] e_cyc, input logic [15:0] e_pc,
                                     input logic [15:0] e_dl, input logic e_fault);
        exp_t e;
        e.tag = tag;
        e.st  = {e_ir, e_cyc, e_pc, e_dl, e_fault};
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_jmp_ind_program();
        mem[16'h8000] = 8'h6C;
        mem[16'h8001] = 8'h40;
        mem[16'h8002] = 8'h30;
        mem[16'h3040] = 8'h34;
        mem[16'h3041] = 8'h12;
        mem[16'h1234] = 8'hEA;
        mem[16'h1235] = 8'hEA;
    endtask

    task automatic test_reset();
        exp_t  e;
        snap_t got;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hEA;
        mem[16'h8002] = 8'hEA;
        use_rom = 1'b1;
        use_mem = 1'b1;
        do_reset();
        #1;
        got = observe();
        checks++;
        if (got !== snap_t'(47'h0) + {8'h00, 6'h00, 16'h8000, 16'h0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got %h want %h", got, {8'h00, 6'h00, 16'h8000, 16'h0000, 1'b0});
        end
        checks++;
        if (sync !== 1'b1 || addr !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL reset_fetch sync=%b addr=%h want sync=1 addr=8000", sync, addr);
        end
        push_exp("reset_e1", 8'hEA, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        push_exp("reset_e2", 8'hEA, 6'b000001, 16'h8002, 16'h0000, 1'b0);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_jmp_ind();
        exp_t  e;
        snap_t got;
        load_jmp_ind_program();
        use_rom = 1'b1;
        use_mem = 1'b1;
        do_reset();
        push_exp("jmp_e0", 8'h6C, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        push_exp("jmp_e1", 8'h6C, 6'b000010, 16'h8002, 16'h0040, 1'b0);
        push_exp("jmp_e2", 8'h6C, 6'b000100, 16'h8003, 16'h3040, 1'b0);
        push_exp("jmp_e3", 8'h6C, 6'b001000, 16'h8034, 16'h3041, 1'b0);
        push_exp("jmp_e4", 8'h6C, 6'b010000, 16'h1234, 16'h3041, 1'b0);
        push_exp("jmp_e5", 8'hEA, 6'b000001, 16'h1235, 16'h3041, 1'b0);
        push_exp("jmp_e6", 8'hEA, 6'b000001, 16'h1236, 16'h3041, 1'b0);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ready_stall();
        exp_t  e;
        snap_t got;
        load_jmp_ind_program();
        use_rom = 1'b1;
        use_mem = 1'b1;
        do_reset();
        push_exp("stall_e0", 8'h6C, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        push_exp("stall_e1", 8'h6C, 6'b000010, 16'h8002, 16'h0040, 1'b0);
        push_exp("stall_e2", 8'h6C, 6'b000100, 16'h8003, 16'h3040, 1'b0);
        for (int k = 0; k < 3; k++)
            push_exp($sformatf("stall_hold%0d", k), 8'h6C, 6'b000100, 16'h8003, 16'h3040, 1'b0);
        push_exp("stall_e3", 8'h6C, 6'b001000, 16'h8034, 16'h3041, 1'b0);
        push_exp("stall_e4", 8'h6C, 6'b010000, 16'h1234, 16'h3041, 1'b0);
        push_exp("stall_e5", 8'hEA, 6'b000001, 16'h1235, 16'h3041, 1'b0);
        for (int s = 0; s < 9; s++) begin
            ready = !(s >= 3 && s <= 5);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
            if (s == 3) begin
                checks++;
                if (addr !== 16'h3040 || sync !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_addr addr=%h sync=%b want addr=3040 sync=0", addr, sync);
                end
            end
            @(negedge clk);
        end
        ready = 1'b1;
    endtask

    task automatic test_overflow();
        exp_t  e;
        snap_t got;
        mem[16'h8000] = 8'h02;
        mem[16'h8001] = 8'hEA;
        mem[16'h8002] = 8'hEA;
        use_rom = 1'b1;
        use_mem = 1'b1;
        do_reset();
        push_exp("ovf_fetch", 8'h02, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_t2",    8'h02, 6'b000010, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_t3",    8'h02, 6'b000100, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_t4",    8'h02, 6'b001000, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_t5",    8'h02, 6'b010000, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_t6",    8'h02, 6'b100000, 16'h8001, 16'h0000, 1'b0);
        push_exp("ovf_wrap",  8'h00, 6'b000000, 16'h8001, 16'h0000, 1'b1);
        push_exp("ovf_refet", 8'hEA, 6'b000001, 16'h8002, 16'h0000, 1'b0);
        push_exp("ovf_nop",   8'hEA, 6'b000001, 16'h8003, 16'h0000, 1'b0);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_direct_latch();
        exp_t       e;
        snap_t      got;
        logic [7:0] xs [9];
        logic [7:0] ds [9];
        xs = '{XB_PCL | XB_PCH, XB_PCL, XB_INC_PC | XB_PCL, XB_DLL | XB_DLH,
               XB_AM_DL | XB_INC_DL, XB_INC_DL | XB_DLH,
               XB_INC_PC | XB_PCL | XB_PCH, XB_INC_PC | XB_INC_DL, XB_SYNC};
        ds = '{8'h12, 8'hFF, 8'hAB, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h00, 8'h77};
        use_rom = 1'b0;
        use_mem = 1'b0;
        x_drv   = 8'h00;
        do_reset();
        for (int s = 0; s < 9; s++) begin
            x_drv   = xs[s];
            din_drv = ds[s];
            case (s)
                0: push_exp("dir_both_pc",  8'h00, 6'b000001, 16'h1212, 16'h0000, 1'b0);
                1: push_exp("dir_pcl",      8'h00, 6'b000010, 16'h12FF, 16'h0000, 1'b0);
                2: push_exp("dir_carry_pc", 8'h00, 6'b000100, 16'h13AB, 16'h0000, 1'b0);
                3: push_exp("dir_both_dl",  8'h00, 6'b001000, 16'h13AB, 16'hFFFF, 1'b0);
                4: push_exp("dir_wrap_dl",  8'h00, 6'b010000, 16'h13AB, 16'h0000, 1'b0);
                5: push_exp("dir_inc_dlh",  8'h00, 6'b100000, 16'h13AB, 16'h5A01, 1'b0);
                6: push_exp("dir_ovf_upd",  8'h00, 6'b000000, 16'hC3C3, 16'h5A01, 1'b1);
                7: push_exp("dir_inc_both", 8'h00, 6'b000001, 16'hC3C4, 16'h5A02, 1'b0);
                default: push_exp("dir_sync", 8'h77, 6'b000001, 16'hC3C4, 16'h5A02, 1'b0);
            endcase
            #1;
            if (s == 0) begin
                checks++;
                if (sync !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL dir_nosync sync=%b want 0", sync);
                end
            end
            if (s == 4) begin
                checks++;
                if (addr !== 16'hFFFF) begin
                    errors++;
                    $display("[TB] FAIL dir_addr_dl addr=%h want ffff", addr);
                end
            end
            if (s == 8) begin
                checks++;
                if (sync !== 1'b1 || addr !== 16'hC3C4) begin
                    errors++;
                    $display("[TB] FAIL dir_addr_pc sync=%b addr=%h want sync=1 addr=c3c4", sync, addr);
                end
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
            @(negedge clk);
        end
        use_rom = 1'b1;
        use_mem = 1'b1;
    endtask

    task automatic test_async_reset();
        exp_t  e;
        snap_t got;
        snap_t rst_snap;
        rst_snap = {8'h00, 6'b000000, 16'h8000, 16'h0000, 1'b0};
        load_jmp_ind_program();
        use_rom = 1'b1;
        use_mem = 1'b1;
        do_reset();
        push_exp("arst_e0", 8'h6C, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        push_exp("arst_e1", 8'h6C, 6'b000010, 16'h8002, 16'h0040, 1'b0);
        push_exp("arst_e2", 8'h6C, 6'b000100, 16'h8003, 16'h3040, 1'b0);
        push_exp("arst_e3", 8'h6C, 6'b001000, 16'h8034, 16'h3041, 1'b0);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            got = observe();
            checks++;
            if (got !== e.st) begin
                errors++;
                $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== rst_snap) begin
            errors++;
            $display("[TB] FAIL arst_immediate got %h want %h", got, rst_snap);
        end
        checks++;
        if (addr !== 16'h8000 || sync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arst_addr addr=%h sync=%b want addr=8000 sync=1", addr, sync);
        end
        @(posedge clk);
        #1;
        got = observe();
        checks++;
        if (got !== rst_snap) begin
            errors++;
            $display("[TB] FAIL arst_held got %h want %h", got, rst_snap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_exp("arst_refetch", 8'h6C, 6'b000001, 16'h8001, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got = observe();
        checks++;
        if (got !== e.st) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", e.tag, got, e.st);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] k6502_sequencer bench start");
        test_reset();
        test_jmp_ind();
        test_ready_stall();
        test_overflow();
        test_direct_latch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
